// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multi-cycle MIPS control sequencer. It steps each instruction
//            through fetch, decode, execute, memory and writeback, and drives
//            per-state strobes for a shared ALU and a unified memory. It also
//            counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int CNT_W         = 16,
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              retire;
  logic              mem_rdy;

  // With the handshake disabled, every memory access completes in one cycle.
  assign mem_rdy = mem_ready | ~USE_MEM_READY;

  assign state       = state_q;
  assign instr_count = count_q;

  // State and retired-instruction counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic and Moore-style strobe decode. Only the fetch/branch
  // PC enables and the memory stall exits look at inputs.
  always_comb begin
    state_d  = S_FETCH;
    retire   = 1'b0;
    pc_en    = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsource = 2'b00;
    illegal  = 1'b0;

    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_rdy;
        pc_en   = mem_rdy;
        state_d = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // The branch target is computed here, before beq is recognised.
        alusrcb = 2'b11;
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        // The IR holds the opcode, so only lw or sw can reach this state.
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        // memwrite stays high for the whole stall.
        memwrite = 1'b1;
        iord     = 1'b1;
        state_d  = mem_rdy ? S_FETCH : S_MEMWR;
        retire   = mem_rdy;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsource = 2'b01;
        pc_en    = zero;
        retire   = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_JUMP: begin
        pcsource = 2'b10;
        pc_en    = 1'b1;
        retire   = 1'b1;
      end
      // Codes 12-15: all strobes stay 0, and the next edge goes to FETCH.
      default: state_d = S_FETCH;
    endcase

    // Hold every strobe low while reset is asserted, even though the
    // register already reads FETCH.
    if (!rst_n) begin
      pc_en    = 1'b0;
      iord     = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      aluop    = 2'b00;
      pcsource = 2'b00;
      illegal  = 1'b0;
    end
  end

  // Retired-instruction counter; wraps modulo 2^CNT_W.
  always_comb begin
    count_d = count_q;
    if (retire) count_d = count_q + CNT_ONE;
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed-vector bench for multicycle_control. It runs a
//            per-cycle vector table plus a counter wrap sequence on a narrow,
//            handshake-free instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  // Strobe word bit order:
  // {pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
  //  alusrca, alusrcb[1:0], aluop[1:0], pcsource[1:0], illegal}
  localparam logic [15:0] E_RST    = 16'h0000;
  localparam logic [15:0] E_FETCH  = 16'hA820;
  localparam logic [15:0] E_FSTALL = 16'h2020;
  localparam logic [15:0] E_DEC    = 16'h0060;
  localparam logic [15:0] E_DECILL = 16'h0061;
  localparam logic [15:0] E_MEMADR = 16'h00C0;
  localparam logic [15:0] E_MEMRD  = 16'h6000;
  localparam logic [15:0] E_MEMWB  = 16'h0500;
  localparam logic [15:0] E_MEMWR  = 16'h5000;
  localparam logic [15:0] E_EXEC   = 16'h0090;
  localparam logic [15:0] E_ALUWB  = 16'h0300;
  localparam logic [15:0] E_BRZ0   = 16'h008A;
  localparam logic [15:0] E_BRZ1   = 16'h808A;
  localparam logic [15:0] E_ADDIEX = 16'h00C0;
  localparam logic [15:0] E_ADDIWB = 16'h0100;
  localparam logic [15:0] E_JUMP   = 16'h8004;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, RT = 6'b000000;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] sb;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite;
  logic        alusrca, illegal;
  logic [1:0]  alusrcb, aluop, pcsource;
  logic [3:0]  state;
  logic [15:0] instr_count;

  logic        rst2_n = 1'b0;
  logic        pc_en2, iord2, memread2, memwrite2, irwrite2, memtoreg2, regdst2;
  logic        regwrite2, alusrca2, illegal2;
  logic [1:0]  alusrcb2, aluop2, pcsource2;
  logic [3:0]  state2;
  logic [1:0]  count2;

  int total = 0;
  int bad   = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(16), .USE_MEM_READY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .memread(memread), .memwrite(memwrite),
    .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource),
    .illegal(illegal), .state(state), .instr_count(instr_count)
  );

  // Narrow counter with the handshake disabled: mem_ready is tied low and
  // must be ignored.
  multicycle_control #(.CNT_W(2), .USE_MEM_READY(1'b0)) dut2 (
    .clk(clk), .rst_n(rst2_n), .opcode(JMP), .zero(1'b0), .mem_ready(1'b0),
    .pc_en(pc_en2), .iord(iord2), .memread(memread2), .memwrite(memwrite2),
    .irwrite(irwrite2), .memtoreg(memtoreg2), .regdst(regdst2), .regwrite(regwrite2),
    .alusrca(alusrca2), .alusrcb(alusrcb2), .aluop(aluop2), .pcsource(pcsource2),
    .illegal(illegal2), .state(state2), .instr_count(count2)
  );

  task automatic chk(input string name, input int idx, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] op, input logic z,
                     input logic mr, input logic [3:0] st, input logic [15:0] sb,
                     input logic [15:0] cnt);
    vec_t v;
    v.rst_n = r; v.op = op; v.z = z; v.mr = mr; v.st = st; v.sb = sb; v.cnt = cnt;
    vq.push_back(v);
  endtask

  initial begin
    logic [15:0] sbw;
    // Reset, then lw with no stall: states 0,1,2,3,4.
    add(0, LW,   0, 1, 4'd0,  E_RST,    16'd0);
    add(1, LW,   0, 1, 4'd0,  E_FETCH,  16'd0);
    add(1, LW,   0, 1, 4'd1,  E_DEC,    16'd0);
    add(1, LW,   0, 1, 4'd2,  E_MEMADR, 16'd0);
    add(1, LW,   0, 1, 4'd3,  E_MEMRD,  16'd0);
    add(1, LW,   0, 1, 4'd4,  E_MEMWB,  16'd0);
    // sw with three stall cycles in MEMWR.
    add(1, SW,   0, 1, 4'd0,  E_FETCH,  16'd1);
    add(1, SW,   0, 1, 4'd1,  E_DEC,    16'd1);
    add(1, SW,   0, 1, 4'd2,  E_MEMADR, 16'd1);
    add(1, SW,   0, 0, 4'd5,  E_MEMWR,  16'd1);
    add(1, SW,   0, 0, 4'd5,  E_MEMWR,  16'd1);
    add(1, SW,   0, 0, 4'd5,  E_MEMWR,  16'd1);
    add(1, SW,   0, 1, 4'd5,  E_MEMWR,  16'd1);
    // beq taken, then not taken.
    add(1, BEQ,  1, 1, 4'd0,  E_FETCH,  16'd2);
    add(1, BEQ,  1, 1, 4'd1,  E_DEC,    16'd2);
    add(1, BEQ,  1, 1, 4'd8,  E_BRZ1,   16'd2);
    add(1, BEQ,  0, 1, 4'd0,  E_FETCH,  16'd3);
    add(1, BEQ,  0, 1, 4'd1,  E_DEC,    16'd3);
    add(1, BEQ,  0, 1, 4'd8,  E_BRZ0,   16'd3);
    // addi, j, R-type back to back; mem_ready low in EXEC is ignored.
    add(1, ADDI, 0, 1, 4'd0,  E_FETCH,  16'd4);
    add(1, ADDI, 0, 1, 4'd1,  E_DEC,    16'd4);
    add(1, ADDI, 0, 1, 4'd9,  E_ADDIEX, 16'd4);
    add(1, ADDI, 0, 1, 4'd10, E_ADDIWB, 16'd4);
    add(1, JMP,  0, 1, 4'd0,  E_FETCH,  16'd5);
    add(1, JMP,  0, 1, 4'd1,  E_DEC,    16'd5);
    add(1, JMP,  0, 1, 4'd11, E_JUMP,   16'd5);
    add(1, RT,   0, 1, 4'd0,  E_FETCH,  16'd6);
    add(1, RT,   0, 1, 4'd1,  E_DEC,    16'd6);
    add(1, RT,   0, 0, 4'd6,  E_EXEC,   16'd6);
    add(1, RT,   0, 1, 4'd7,  E_ALUWB,  16'd6);
    // Illegal opcode: one DECODE cycle with the pulse, back to FETCH, no count.
    add(1, BAD,  0, 1, 4'd0,  E_FETCH,  16'd7);
    add(1, BAD,  0, 1, 4'd1,  E_DECILL, 16'd7);
    add(1, BAD,  0, 0, 4'd0,  E_FSTALL, 16'd7);
    // lw with a fetch stall above, then a read stall.
    add(1, LW,   0, 1, 4'd0,  E_FETCH,  16'd7);
    add(1, LW,   0, 1, 4'd1,  E_DEC,    16'd7);
    add(1, LW,   0, 1, 4'd2,  E_MEMADR, 16'd7);
    add(1, LW,   0, 0, 4'd3,  E_MEMRD,  16'd7);
    add(1, LW,   0, 1, 4'd3,  E_MEMRD,  16'd7);
    add(1, LW,   0, 1, 4'd4,  E_MEMWB,  16'd7);
    // sw stalled in MEMWR, then aborted by reset.
    add(1, SW,   0, 1, 4'd0,  E_FETCH,  16'd8);
    add(1, SW,   0, 1, 4'd1,  E_DEC,    16'd8);
    add(1, SW,   0, 1, 4'd2,  E_MEMADR, 16'd8);
    add(1, SW,   0, 0, 4'd5,  E_MEMWR,  16'd8);
    add(0, SW,   0, 0, 4'd0,  E_RST,    16'd0);
    add(1, LW,   0, 1, 4'd0,  E_FETCH,  16'd0);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #2;
      rst_n = vq[i].rst_n; opcode = vq[i].op; zero = vq[i].z; mem_ready = vq[i].mr;
      #2;
      sbw = {pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
             alusrca, alusrcb, aluop, pcsource, illegal};
      chk("state", i, {12'd0, state}, {12'd0, vq[i].st});
      chk("strobes", i, sbw, vq[i].sb);
      chk("instr_count", i, instr_count, vq[i].cnt);
    end

    // Wrap test: four jumps on a 2-bit counter give 1,2,3,0.
    @(posedge clk);
    #2 rst2_n = 1'b1;
    #2 chk("wrap_state_rst", 0, {12'd0, state2}, 16'd0);
    chk("wrap_cnt_rst", 0, {14'd0, count2}, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      repeat (3) @(posedge clk);
      #4;
      chk("wrap_state", k, {12'd0, state2}, 16'd0);
      chk("wrap_cnt", k, {14'd0, count2}, 16'(k % 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
